// File: rtl/xilinx_lutram_fifo.sv
// Synchronous FIFO built on simple-dual-port distributed RAM, followed by a
// registered first-word-fall-through output stage with valid/ready handshake.
//
// state     | meaning
// ST_EMPTY  | output register holds no entry
// ST_VALID  | output register holds the head-of-queue word
module xilinx_lutram_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 64,
  parameter int AFULL_THR  = DEPTH - 4,
  parameter int AEMPTY_THR = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  output logic                         full,
  output logic                         almost_full,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+2)-1:0]   level,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(DEPTH + 2);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THR);
  localparam logic [LW-1:0] AEMPTY_C = LW'(AEMPTY_THR);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_VALID = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    ram_count;
  logic [CW-1:0]    count_next;
  logic [LW-1:0]    level_next;
  logic             we;
  logic             load;
  logic             valid_next;

  // full is the registered flag, so a write racing a RAM read still drops
  always_comb begin
    we         = wr_en & ~full;
    load       = (ram_count != '0) & (~out_valid | out_ready);
    count_next = ram_count;
    if (we && !load) begin
      count_next = ram_count + CW'(1);
    end else if (!we && load) begin
      count_next = ram_count - CW'(1);
    end
    valid_next = load | (out_valid & ~out_ready);
    level_next = LW'(count_next) + LW'(valid_next);
  end

  // LUTRAM column: no reset, async read
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_EMPTY;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_count    <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      level        <= '0;
      overflow     <= 1'b0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (load) begin
        out_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end

      case (state)
        ST_EMPTY: begin
          if (ram_count != '0) begin
            state     <= ST_VALID;
            out_valid <= 1'b1;
          end
        end
        ST_VALID: begin
          if (out_ready && ram_count == '0) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
        end
      endcase

      ram_count    <= count_next;
      full         <= (count_next == DEPTH_C);
      almost_full  <= (count_next >= AFULL_C);
      level        <= level_next;
      almost_empty <= (level_next <= AEMPTY_C);
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xilinx_lutram_fifo.sv
// Directed and scoreboard-checked bench for xilinx_lutram_fifo (WIDTH=8, DEPTH=64).
module tb_xilinx_lutram_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int LW    = $clog2(DEPTH + 2);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             out_ready = 1'b0;
  logic             full;
  logic             almost_full;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             almost_empty;
  logic [LW-1:0]    level;
  logic             overflow;

  int checks = 0;
  int passes = 0;

  logic [WIDTH-1:0] mq [$];
  logic             m_ov;
  logic             m_ovf;
  logic [WIDTH-1:0] m_od;

  xilinx_lutram_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AFULL_THR(DEPTH - 4),
    .AEMPTY_THR(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .full(full),
    .almost_full(almost_full),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .almost_empty(almost_empty),
    .level(level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    wr_en     = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #2;
    wr_en = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, full, almost_full, almost_empty, overflow} !== 5'b00010)
      $display("FAIL reset_flags: got %b want 00010", {out_valid, full, almost_full, almost_empty, overflow});
    else passes++;
    checks++;
    if (level !== LW'(0)) $display("FAIL reset_level: got %0d want 0", level);
    else passes++;
    checks++;
    if (out_data !== 8'h00) $display("FAIL reset_data: got %0h want 0", out_data);
    else passes++;
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({out_valid, full, almost_empty, level} !== {1'b0, 1'b0, 1'b1, LW'(0)})
      $display("FAIL reset_release: got v=%b f=%b ae=%b lvl=%0d want 0 0 1 0", out_valid, full, almost_empty, level);
    else passes++;
  endtask

  task automatic test_single_write();
    apply_reset();
    wr_data = 8'hA5;
    wr_en   = 1'b1;
    step();
    wr_en = 1'b0;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL latency_edge1_valid: got %b want 0", out_valid);
    else passes++;
    checks++;
    if (level !== LW'(1)) $display("FAIL latency_edge1_level: got %0d want 1", level);
    else passes++;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5)
      $display("FAIL latency_edge2: got v=%b d=%0h want v=1 d=a5", out_valid, out_data);
    else passes++;
    checks++;
    if (level !== LW'(1) || almost_empty !== 1'b1)
      $display("FAIL single_flags: got lvl=%0d ae=%b want 1 1", level, almost_empty);
    else passes++;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5)
      $display("FAIL hold_no_ready: got v=%b d=%0h want v=1 d=a5", out_valid, out_data);
    else passes++;
  endtask

  task automatic test_fill_overflow();
    apply_reset();
    for (int i = 0; i < 65; i++) begin
      wr_data = 8'(8'h10 + i);
      wr_en   = 1'b1;
      step();
      if (i == 59) begin
        checks++;
        if (almost_full !== 1'b0) $display("FAIL afull_below: got %b want 0", almost_full);
        else passes++;
      end
      if (i == 60) begin
        checks++;
        if (almost_full !== 1'b1) $display("FAIL afull_at_thr: got %b want 1", almost_full);
        else passes++;
      end
      if (i == 63) begin
        checks++;
        if (full !== 1'b0 || level !== LW'(64))
          $display("FAIL fill_64: got f=%b lvl=%0d want 0 64", full, level);
        else passes++;
      end
    end
    checks++;
    if (full !== 1'b1 || level !== LW'(65) || overflow !== 1'b0)
      $display("FAIL fill_65: got f=%b lvl=%0d ovf=%b want 1 65 0", full, level, overflow);
    else passes++;
    wr_data = 8'hEE;
    step();
    wr_en = 1'b0;
    checks++;
    if (overflow !== 1'b1 || level !== LW'(65) || full !== 1'b1)
      $display("FAIL overflow: got ovf=%b lvl=%0d f=%b want 1 65 1", overflow, level, full);
    else passes++;
    checks++;
    if (out_data !== 8'h10) $display("FAIL fill_head: got %0h want 10", out_data);
    else passes++;
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    for (int k = 0; k < 65; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(8'h10 + k))
        $display("FAIL drain_word%0d: got v=%b d=%0h want v=1 d=%0h", k, out_valid, out_data, 8'(8'h10 + k));
      else passes++;
      if (k == 62) begin
        checks++;
        if (almost_empty !== 1'b0 || level !== LW'(3))
          $display("FAIL aempty_above: got ae=%b lvl=%0d want 0 3", almost_empty, level);
        else passes++;
      end
      if (k == 63) begin
        checks++;
        if (almost_empty !== 1'b1 || level !== LW'(2))
          $display("FAIL aempty_at_thr: got ae=%b lvl=%0d want 1 2", almost_empty, level);
        else passes++;
      end
      step();
    end
    checks++;
    if ({out_valid, full, almost_empty, overflow} !== 4'b0011 || level !== LW'(0))
      $display("FAIL drain_end: got v=%b f=%b ae=%b ovf=%b lvl=%0d want 0 0 1 1 0",
               out_valid, full, almost_empty, overflow, level);
    else passes++;
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    apply_reset();
    out_ready = 1'b1;
    wr_en     = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wr_data = 8'(i);
      step();
      checks++;
      if (level !== LW'((i == 0) ? 1 : 2))
        $display("FAIL stream_level%0d: got %0d want %0d", i, level, (i == 0) ? 1 : 2);
      else passes++;
      if (i >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'(i - 1))
          $display("FAIL stream_word%0d: got v=%b d=%0h want v=1 d=%0h", i - 1, out_valid, out_data, 8'(i - 1));
        else passes++;
      end
    end
    wr_en = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'(299) || level !== LW'(1))
      $display("FAIL stream_last: got v=%b d=%0h lvl=%0d want 1 2b 1", out_valid, out_data, level);
    else passes++;
    step();
    checks++;
    if (out_valid !== 1'b0 || level !== LW'(0))
      $display("FAIL stream_empty: got v=%b lvl=%0d want 0 0", out_valid, level);
    else passes++;
    out_ready = 1'b0;
  endtask

  task automatic test_random(input int cycles, input int wr_pct, input int rd_pct);
    int          lvl;
    logic [10:0] exp_vec;
    logic [10:0] got_vec;
    logic        m_full;
    logic        m_load;
    apply_reset();
    mq.delete();
    m_ov  = 1'b0;
    m_ovf = 1'b0;
    m_od  = '0;
    for (int c = 0; c < cycles; c++) begin
      wr_en     = ($urandom_range(0, 99) < wr_pct);
      out_ready = ($urandom_range(0, 99) < rd_pct);
      wr_data   = 8'($urandom);
      m_full = (mq.size() == DEPTH);
      m_load = (mq.size() != 0) && (!m_ov || out_ready);
      if (wr_en && m_full) m_ovf = 1'b1;
      if (m_load) begin
        m_od = mq.pop_front();
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (wr_en && !m_full) mq.push_back(wr_data);
      step();
      lvl = mq.size() + int'(m_ov);
      exp_vec = {m_ov, (mq.size() == DEPTH), (mq.size() >= DEPTH - 4), (lvl <= 2), m_ovf, LW'(lvl)};
      got_vec = {out_valid, full, almost_full, almost_empty, overflow, level};
      checks++;
      if (got_vec !== exp_vec)
        $display("FAIL rand_flags c%0d: got %b want %b", c, got_vec, exp_vec);
      else passes++;
      if (m_ov) begin
        checks++;
        if (out_data !== m_od) $display("FAIL rand_data c%0d: got %0h want %0h", c, out_data, m_od);
        else passes++;
      end
    end
    wr_en     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wr_data = 8'(8'h80 + i);
      step();
    end
    wr_en = 1'b0;
    step();
    checks++;
    if (level !== LW'(32) || out_valid !== 1'b1)
      $display("FAIL half_full: got lvl=%0d v=%b want 32 1", level, out_valid);
    else passes++;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, full, almost_full, almost_empty, overflow} !== 5'b00010 || level !== LW'(0) || out_data !== 8'h00)
      $display("FAIL mid_reset: got v=%b f=%b af=%b ae=%b ovf=%b lvl=%0d d=%0h want 0 0 0 1 0 0 0",
               out_valid, full, almost_full, almost_empty, overflow, level, out_data);
    else passes++;
    step();
    rst_n   = 1'b1;
    wr_data = 8'h3C;
    wr_en   = 1'b1;
    step();
    wr_en = 1'b0;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL post_reset_edge1: got v=%b want 0", out_valid);
    else passes++;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C || level !== LW'(1))
      $display("FAIL post_reset_first: got v=%b d=%0h lvl=%0d want 1 3c 1", out_valid, out_data, level);
    else passes++;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_write();
    test_fill_overflow();
    test_drain();
    test_stream();
    test_random(10000, 50, 50);
    test_random(3000, 80, 25);
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
